// File: rtl/phase_sequencer_pkg.sv
// Shared types and defaults for the phase sequencer and its phase counter.
// Latency: none (declarations only).
// Backpressure: n/a.
package phase_sequencer_pkg;

  // Sequencer states. The encodings are fixed because the debug front panel decodes them.
  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } seq_state_t;

  // Classic FT/DC/EX/WB machine.
  localparam int DEF_NUM_PHASES = 4;

endpackage

// File: rtl/phase_sequencer_phase_counter.sv
// Wrapping mod-NUM_PHASES index counter with enable and wrap flag.
// Latency: idx advances on the clock edge where en=1; wrap is combinational.
// Backpressure: en=0 holds idx (the caller applies stall/halt through en).
// Ports: CLK, RESET_N (async active-low), en (advance), idx (current index),
//        wrap (en while idx is the last phase, i.e. this edge returns idx to 0).
module phase_counter
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int IDX_W      = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             wrap
);

  logic last;

  assign last = (idx == IDX_W'(NUM_PHASES - 1));
  assign wrap = en & last;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx <= '0;
    end else if (en) begin
      idx <= last ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// One-hot CPU phase-enable generator with stall, halt-at-boundary, single-step and cycle count.
// Latency: a phase appears on PHASE one clock after its index is current on PHASE_IDX.
// Backpressure: STALL freezes phase, index, state and count; halts wait for the cycle boundary.
// Ports: CLK, RESET_N (async active-low); RUN (level), STEP (pulse), STALL (hold);
//        PHASE (registered one-hot), PHASE_IDX (next phase), CYCLE_END (last phase, not stalled),
//        HALTED (registered), CYCLE_CNT (instruction cycles started, wraps).
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES    = DEF_NUM_PHASES,
  parameter int IDX_W         = 2,
  parameter int CNT_W         = 16,
  parameter int START_RUNNING = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  RUN,
  input  logic                  STEP,
  input  logic                  STALL,
  output logic [NUM_PHASES-1:0] PHASE,
  output logic [IDX_W-1:0]      PHASE_IDX,
  output logic                  CYCLE_END,
  output logic                  HALTED,
  output logic [CNT_W-1:0]      CYCLE_CNT
);

  seq_state_t state;
  logic       step_done;  // STEP state has issued its last phase
  logic       is_zero;
  logic       wrap;
  logic       start;      // HALT -> RUN/STEP, issuing phase 0 on the same edge
  logic       leave;      // active state returns to HALT at this boundary
  logic       issue;

  phase_counter #(
    .NUM_PHASES (NUM_PHASES),
    .IDX_W      (IDX_W)
  ) u_phase_counter (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .en      (issue),
    .idx     (PHASE_IDX),
    .wrap    (wrap)
  );

  assign is_zero   = (PHASE_IDX == '0);
  assign CYCLE_END = PHASE[NUM_PHASES-1] & ~STALL;

  always_comb begin
    start = 1'b0;
    leave = 1'b0;
    issue = 1'b0;
    case (state)
      S_HALT: begin
        // STALL is deliberately ignored while halted.
        start = RUN | STEP;
        issue = start;
      end
      S_RUN: begin
        leave = is_zero & ~RUN;
        issue = ~STALL & ~leave;
      end
      S_STEP: begin
        // A step always completes back to HALT, even if RUN rose meanwhile;
        // RUN is only resampled once halted.
        leave = step_done;
        issue = ~STALL & ~leave;
      end
      default: begin
        issue = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= (START_RUNNING != 0) ? S_RUN : S_HALT;
      HALTED    <= (START_RUNNING == 0);
      PHASE     <= '0;
      CYCLE_CNT <= '0;
      step_done <= 1'b0;
    end else begin
      case (state)
        S_HALT: begin
          if (RUN) begin
            state  <= S_RUN;
            HALTED <= 1'b0;
          end else if (STEP) begin
            state     <= S_STEP;
            HALTED    <= 1'b0;
            step_done <= 1'b0;
          end
        end
        S_RUN, S_STEP: begin
          if (!STALL && leave) begin
            state  <= S_HALT;
            HALTED <= 1'b1;
            PHASE  <= '0;
          end
        end
        default: begin
          state  <= S_HALT;
          HALTED <= 1'b1;
          PHASE  <= '0;
        end
      endcase

      if (issue) begin
        PHASE <= NUM_PHASES'(1) << PHASE_IDX;
        if (is_zero) begin
          CYCLE_CNT <= CYCLE_CNT + CNT_W'(1);
        end
      end

      // Only a wrap issued inside STEP marks the single cycle as complete.
      if (state == S_STEP && wrap) begin
        step_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: three instances cover the default
// 4-phase machine, a 5-phase machine with a 3-bit counter, and START_RUNNING=0.
module tb_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Instance A: defaults
  logic       a_rst_n, a_run, a_step, a_stall;
  logic [3:0] a_phase;
  logic [1:0] a_idx;
  logic       a_end, a_halted;
  logic [15:0] a_cnt;

  // Instance B: 5 phases, 3-bit counter
  logic       b_rst_n, b_run, b_step, b_stall;
  logic [4:0] b_phase;
  logic [2:0] b_idx;
  logic       b_end, b_halted;
  logic [2:0] b_cnt;

  // Instance C: leaves reset halted
  logic       c_rst_n, c_run, c_step, c_stall;
  logic [3:0] c_phase;
  logic [1:0] c_idx;
  logic       c_end, c_halted;
  logic [15:0] c_cnt;

  phase_sequencer u_a (
    .CLK(clk), .RESET_N(a_rst_n), .RUN(a_run), .STEP(a_step), .STALL(a_stall),
    .PHASE(a_phase), .PHASE_IDX(a_idx), .CYCLE_END(a_end), .HALTED(a_halted), .CYCLE_CNT(a_cnt)
  );

  phase_sequencer #(.NUM_PHASES(5), .IDX_W(3), .CNT_W(3), .START_RUNNING(1)) u_b (
    .CLK(clk), .RESET_N(b_rst_n), .RUN(b_run), .STEP(b_step), .STALL(b_stall),
    .PHASE(b_phase), .PHASE_IDX(b_idx), .CYCLE_END(b_end), .HALTED(b_halted), .CYCLE_CNT(b_cnt)
  );

  phase_sequencer #(.NUM_PHASES(4), .IDX_W(2), .CNT_W(16), .START_RUNNING(0)) u_c (
    .CLK(clk), .RESET_N(c_rst_n), .RUN(c_run), .STEP(c_step), .STALL(c_stall),
    .PHASE(c_phase), .PHASE_IDX(c_idx), .CYCLE_END(c_end), .HALTED(c_halted), .CYCLE_CNT(c_cnt)
  );

  // Advance one active edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; a_run = 1'b1; a_step = 1'b0; a_stall = 1'b0;
    b_rst_n = 1'b0; b_run = 1'b0; b_step = 1'b0; b_stall = 1'b0;
    c_rst_n = 1'b0; c_run = 1'b0; c_step = 1'b0; c_stall = 1'b0;
    @(negedge clk);
    total++; if (a_phase !== 4'b0000) $display("FAIL rst_a_phase got=%b exp=0000", a_phase); else passed++;
    total++; if (a_idx !== 2'd0) $display("FAIL rst_a_idx got=%0d exp=0", a_idx); else passed++;
    total++; if (a_cnt !== 16'd0) $display("FAIL rst_a_cnt got=%0d exp=0", a_cnt); else passed++;
    total++; if (a_halted !== 1'b0) $display("FAIL rst_a_halted got=%b exp=0", a_halted); else passed++;
    total++; if (b_phase !== 5'b00000) $display("FAIL rst_b_phase got=%b exp=00000", b_phase); else passed++;
    total++; if (c_halted !== 1'b1) $display("FAIL rst_c_halted got=%b exp=1", c_halted); else passed++;
    total++; if (c_phase !== 4'b0000) $display("FAIL rst_c_phase got=%b exp=0000", c_phase); else passed++;
    a_rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    logic [3:0] exp_p;
    logic [15:0] exp_c;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_p = 4'b0001 << (i % 4);
      exp_c = (i < 4) ? 16'd1 : 16'd2;
      total++; if (a_phase !== exp_p) $display("FAIL run_phase[%0d] got=%b exp=%b", i, a_phase, exp_p); else passed++;
      total++; if (a_cnt !== exp_c) $display("FAIL run_cnt[%0d] got=%0d exp=%0d", i, a_cnt, exp_c); else passed++;
      total++; if (a_end !== (i == 3)) $display("FAIL run_end[%0d] got=%b exp=%b", i, a_end, (i == 3)); else passed++;
    end
  endtask

  task automatic test_stall();
    tick();
    total++; if (a_phase !== 4'b0010) $display("FAIL stall_pre got=%b exp=0010", a_phase); else passed++;
    a_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (a_phase !== 4'b0010) $display("FAIL stall_hold[%0d] got=%b exp=0010", i, a_phase); else passed++;
      total++; if (a_idx !== 2'd2) $display("FAIL stall_idx[%0d] got=%0d exp=2", i, a_idx); else passed++;
      total++; if (a_cnt !== 16'd2) $display("FAIL stall_cnt[%0d] got=%0d exp=2", i, a_cnt); else passed++;
    end
    a_stall = 1'b0;
    tick();
    total++; if (a_phase !== 4'b0100) $display("FAIL stall_post got=%b exp=0100", a_phase); else passed++;
    tick();
    total++; if (a_phase !== 4'b1000) $display("FAIL stall_last got=%b exp=1000", a_phase); else passed++;
    a_stall = 1'b1;
    #1;
    total++; if (a_end !== 1'b0) $display("FAIL stall_end_masked got=%b exp=0", a_end); else passed++;
    tick();
    total++; if (a_phase !== 4'b1000) $display("FAIL stall_last_hold got=%b exp=1000", a_phase); else passed++;
    a_stall = 1'b0;
    #1;
    total++; if (a_end !== 1'b1) $display("FAIL stall_end_release got=%b exp=1", a_end); else passed++;
    tick();
    total++; if (a_phase !== 4'b0001) $display("FAIL stall_wrap got=%b exp=0001", a_phase); else passed++;
    total++; if (a_cnt !== 16'd3) $display("FAIL stall_wrap_cnt got=%0d exp=3", a_cnt); else passed++;
  endtask

  task automatic test_halt();
    tick();
    total++; if (a_phase !== 4'b0010) $display("FAIL halt_pre got=%b exp=0010", a_phase); else passed++;
    a_run = 1'b0;
    tick();
    total++; if (a_phase !== 4'b0100) $display("FAIL halt_p2 got=%b exp=0100", a_phase); else passed++;
    tick();
    total++; if (a_phase !== 4'b1000) $display("FAIL halt_p3 got=%b exp=1000", a_phase); else passed++;
    total++; if (a_halted !== 1'b0) $display("FAIL halt_early got=%b exp=0", a_halted); else passed++;
    tick();
    total++; if (a_phase !== 4'b0000) $display("FAIL halt_phase got=%b exp=0000", a_phase); else passed++;
    total++; if (a_halted !== 1'b1) $display("FAIL halt_flag got=%b exp=1", a_halted); else passed++;
    total++; if (a_idx !== 2'd0) $display("FAIL halt_idx got=%0d exp=0", a_idx); else passed++;
    a_stall = 1'b1;
    tick();
    a_stall = 1'b0;
    total++; if (a_phase !== 4'b0000) $display("FAIL halt_stay got=%b exp=0000", a_phase); else passed++;
    total++; if (a_cnt !== 16'd3) $display("FAIL halt_cnt got=%0d exp=3", a_cnt); else passed++;
  endtask

  task automatic test_step();
    a_step = 1'b1;
    tick();
    a_step = 1'b0;
    total++; if (a_phase !== 4'b0001) $display("FAIL step_p0 got=%b exp=0001", a_phase); else passed++;
    total++; if (a_halted !== 1'b0) $display("FAIL step_halted got=%b exp=0", a_halted); else passed++;
    total++; if (a_cnt !== 16'd4) $display("FAIL step_cnt got=%0d exp=4", a_cnt); else passed++;
    tick();
    total++; if (a_phase !== 4'b0010) $display("FAIL step_p1 got=%b exp=0010", a_phase); else passed++;
    a_step = 1'b1;  // ignored while stepping
    tick();
    a_step = 1'b0;
    total++; if (a_phase !== 4'b0100) $display("FAIL step_p2 got=%b exp=0100", a_phase); else passed++;
    tick();
    total++; if (a_phase !== 4'b1000) $display("FAIL step_p3 got=%b exp=1000", a_phase); else passed++;
    tick();
    total++; if (a_phase !== 4'b0000) $display("FAIL step_end got=%b exp=0000", a_phase); else passed++;
    total++; if (a_halted !== 1'b1) $display("FAIL step_end_halted got=%b exp=1", a_halted); else passed++;
    tick();
    total++; if (a_phase !== 4'b0000) $display("FAIL step_no_requeue got=%b exp=0000", a_phase); else passed++;
    total++; if (a_cnt !== 16'd4) $display("FAIL step_cnt_final got=%0d exp=4", a_cnt); else passed++;
    // RUN rising mid-step still finishes the step in HALT first.
    a_step = 1'b1;
    tick();
    a_step = 1'b0;
    a_run = 1'b1;
    tick(); tick(); tick();
    total++; if (a_phase !== 4'b1000) $display("FAIL step_run_p3 got=%b exp=1000", a_phase); else passed++;
    tick();
    total++; if (a_phase !== 4'b0000) $display("FAIL step_run_halt got=%b exp=0000", a_phase); else passed++;
    total++; if (a_halted !== 1'b1) $display("FAIL step_run_halted got=%b exp=1", a_halted); else passed++;
    tick();
    total++; if (a_phase !== 4'b0001) $display("FAIL step_run_resume got=%b exp=0001", a_phase); else passed++;
    total++; if (a_cnt !== 16'd6) $display("FAIL step_run_cnt got=%0d exp=6", a_cnt); else passed++;
  endtask

  task automatic test_wrap5();
    logic [4:0] exp_p;
    logic [2:0] exp_c;
    int ends;
    ends = 0;
    b_run = 1'b1;
    b_rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      exp_p = 5'b00001 << (i % 5);
      exp_c = 3'((i / 5 + 1) % 8);
      if (b_end) ends++;
      total++; if (b_phase !== exp_p) $display("FAIL w5_phase[%0d] got=%b exp=%b", i, b_phase, exp_p); else passed++;
      total++; if (b_cnt !== exp_c) $display("FAIL w5_cnt[%0d] got=%0d exp=%0d", i, b_cnt, exp_c); else passed++;
    end
    total++; if (ends != 8) $display("FAIL w5_cycle_end_count got=%0d exp=8", ends); else passed++;
  endtask

  task automatic test_async_reset();
    c_rst_n = 1'b1;
    tick();
    total++; if (c_halted !== 1'b1) $display("FAIL ar_idle_halted got=%b exp=1", c_halted); else passed++;
    total++; if (c_phase !== 4'b0000) $display("FAIL ar_idle_phase got=%b exp=0000", c_phase); else passed++;
    c_run = 1'b1;
    tick(); tick(); tick();
    total++; if (c_phase !== 4'b0100) $display("FAIL ar_pre got=%b exp=0100", c_phase); else passed++;
    c_run = 1'b0;
    #2 c_rst_n = 1'b0;
    #1;
    total++; if (c_phase !== 4'b0000) $display("FAIL ar_phase got=%b exp=0000", c_phase); else passed++;
    total++; if (c_halted !== 1'b1) $display("FAIL ar_halted got=%b exp=1", c_halted); else passed++;
    total++; if (c_idx !== 2'd0) $display("FAIL ar_idx got=%0d exp=0", c_idx); else passed++;
    total++; if (c_cnt !== 16'd0) $display("FAIL ar_cnt got=%0d exp=0", c_cnt); else passed++;
    @(negedge clk);
    c_rst_n = 1'b1;
    tick();
    total++; if (c_phase !== 4'b0000) $display("FAIL ar_stay got=%b exp=0000", c_phase); else passed++;
    c_run = 1'b1;
    c_step = 1'b1;
    tick();
    c_step = 1'b0;
    total++; if (c_phase !== 4'b0001) $display("FAIL ar_restart got=%b exp=0001", c_phase); else passed++;
    total++; if (c_halted !== 1'b0) $display("FAIL ar_restart_halted got=%b exp=0", c_halted); else passed++;
    total++; if (c_cnt !== 16'd1) $display("FAIL ar_restart_cnt got=%0d exp=1", c_cnt); else passed++;
    tick();
    total++; if (c_phase !== 4'b0010) $display("FAIL ar_next got=%b exp=0010", c_phase); else passed++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_halt();
    test_step();
    test_wrap5();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
